// File: rtl/instr_phase_sequencer.sv
// Multi-cycle instruction phase sequencer: steps fetch/fwait/decode/exec/mem/wb
// on a single clock and emits registered enable strobes for the datapath.
module instr_phase_sequencer #(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned MD_TIMEOUT = 64,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_req,
  input  logic             is_mem,
  input  logic             is_store,
  input  logic             is_md,
  input  logic             md_ready,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             exec_en,
  output logic             md_start,
  output logic             dmem_wren,
  output logic             wb_en,
  output logic             pc_en,
  output logic [2:0]       phase,
  output logic             running,
  output logic             md_timeout,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned WAIT_MAX = (MD_TIMEOUT > MEM_LAT) ? MD_TIMEOUT : MEM_LAT;
  localparam int unsigned CW       = $clog2(WAIT_MAX + 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_FWAIT  = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_MEM    = 3'd5,
    S_WB     = 3'd6,
    S_HALTED = 3'd7
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_abort;

  logic             r_mem_flag;
  logic             r_store_flag;
  logic             r_md_flag;

  logic             r_fetch_en;
  logic             r_decode_en;
  logic             r_exec_en;
  logic             r_md_start;
  logic             r_dmem_wren;
  logic             r_wb_en;
  logic             r_pc_en;
  logic             r_running;
  logic             r_md_timeout;
  logic [CNT_W-1:0] r_instr_count;

  logic             w_fetch_nxt;
  logic             w_decode_nxt;
  logic             w_exec_nxt;
  logic             w_md_start_nxt;
  logic             w_wren_nxt;
  logic             w_wb_nxt;
  logic             w_pc_nxt;
  logic             w_running_nxt;
  logic             w_resume;

  // State register, phase counter and decoded-instruction flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_mem_flag   <= 1'b0;
      r_store_flag <= 1'b0;
      r_md_flag    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (r_state == S_DECODE) begin
        r_mem_flag   <= is_mem;
        r_store_flag <= is_mem & is_store;
        r_md_flag    <= is_md;
      end
    end
  end

  // Next-state logic; the counter only runs in the multi-cycle phases.
  always_comb begin
    w_state_nxt = r_state;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE, S_HALTED: begin
        if (start) w_state_nxt = S_FETCH;
      end
      S_FETCH:  w_state_nxt = (MEM_LAT == 0) ? S_DECODE : S_FWAIT;
      S_FWAIT: begin
        if (32'(r_cnt) + 32'd1 >= MEM_LAT) w_state_nxt = S_DECODE;
      end
      S_DECODE: w_state_nxt = S_EXEC;
      S_EXEC: begin
        if (!r_md_flag) begin
          w_state_nxt = r_mem_flag ? S_MEM : S_WB;
        end else if (r_cnt != '0) begin
          // md_ready is only honoured from the second EXEC cycle on
          if (md_ready) begin
            w_state_nxt = S_WB;
          end else if (32'(r_cnt) >= MD_TIMEOUT) begin
            w_state_nxt = S_WB;
            w_abort     = 1'b1;
          end
        end
      end
      S_MEM: begin
        if (32'(r_cnt) >= MEM_LAT) w_state_nxt = S_WB;
      end
      S_WB:     w_state_nxt = halt_req ? S_HALTED : S_FETCH;
      default:  w_state_nxt = S_IDLE;
    endcase

    w_cnt_nxt = '0;
    if ((w_state_nxt == r_state) &&
        (r_state inside {S_FWAIT, S_EXEC, S_MEM})) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end
  end

  // Output lookahead: strobes are computed from the next state so they register in phase.
  always_comb begin
    w_resume       = (r_state inside {S_IDLE, S_HALTED}) && start;
    w_fetch_nxt    = (w_state_nxt == S_FETCH);
    w_decode_nxt   = (w_state_nxt == S_DECODE);
    w_exec_nxt     = (r_state == S_DECODE);
    w_md_start_nxt = (r_state == S_DECODE) && is_md;
    w_wren_nxt     = (r_state == S_EXEC) && (w_state_nxt == S_MEM) && r_store_flag;
    w_pc_nxt       = (w_state_nxt == S_WB);
    w_wb_nxt       = (w_state_nxt == S_WB) && !r_store_flag && !w_abort;
    w_running_nxt  = !(w_state_nxt inside {S_IDLE, S_HALTED});
  end

  // Registered outputs, retire counter and sticky abort flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fetch_en    <= 1'b0;
      r_decode_en   <= 1'b0;
      r_exec_en     <= 1'b0;
      r_md_start    <= 1'b0;
      r_dmem_wren   <= 1'b0;
      r_wb_en       <= 1'b0;
      r_pc_en       <= 1'b0;
      r_running     <= 1'b0;
      r_md_timeout  <= 1'b0;
      r_instr_count <= '0;
    end else begin
      r_fetch_en  <= w_fetch_nxt;
      r_decode_en <= w_decode_nxt;
      r_exec_en   <= w_exec_nxt;
      r_md_start  <= w_md_start_nxt;
      r_dmem_wren <= w_wren_nxt;
      r_wb_en     <= w_wb_nxt;
      r_pc_en     <= w_pc_nxt;
      r_running   <= w_running_nxt;
      if (w_abort) begin
        r_md_timeout <= 1'b1;
      end else if (w_resume) begin
        r_md_timeout <= 1'b0;
      end
      if (r_state == S_WB) begin
        r_instr_count <= r_instr_count + CNT_W'(1);
      end
    end
  end

  assign fetch_en    = r_fetch_en;
  assign decode_en   = r_decode_en;
  assign exec_en     = r_exec_en;
  assign md_start    = r_md_start;
  assign dmem_wren   = r_dmem_wren;
  assign wb_en       = r_wb_en;
  assign pc_en       = r_pc_en;
  assign phase       = r_state;
  assign running     = r_running;
  assign md_timeout  = r_md_timeout;
  assign instr_count = r_instr_count;

endmodule
